// File: rtl/wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : wb_arbiter
// Purpose  : Round-robin writeback arbiter (ALU / load unit) feeding a single
//            registered regfile write port, with combinational read bypass
//            covering the cycle in which a staged write is not yet visible.
// Revision : 1.0 - initial release
// ============================================================================
module wb_arbiter #(
  parameter int unsigned REG_ADDR_SIZE = 5,
  parameter int unsigned REG_SIZE      = 32,
  parameter int unsigned NUM_REGS      = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  // ALU requester
  input  logic                     alu_valid,
  output logic                     alu_ready,
  input  logic [REG_ADDR_SIZE-1:0] alu_reg,
  input  logic [REG_SIZE-1:0]      alu_data,
  // Load-unit requester
  input  logic                     mem_valid,
  output logic                     mem_ready,
  input  logic [REG_ADDR_SIZE-1:0] mem_reg,
  input  logic [REG_SIZE-1:0]      mem_data,
  // Regfile write port
  output logic                     WriteEnable,
  output logic [REG_ADDR_SIZE-1:0] WriteReg,
  output logic [REG_SIZE-1:0]      WriteData,
  // Read-port bypass
  input  logic [REG_ADDR_SIZE-1:0] RegA,
  input  logic [REG_ADDR_SIZE-1:0] RegB,
  output logic                     fwd_a_hit,
  output logic [REG_SIZE-1:0]      fwd_a_data,
  output logic                     fwd_b_hit,
  output logic [REG_SIZE-1:0]      fwd_b_data
);

  // Priority pointer: which requester wins when both are valid.
  typedef enum logic [0:0] {
    PRIO_ALU = 1'b0,
    PRIO_MEM = 1'b1
  } prio_e;

  localparam logic [REG_ADDR_SIZE-1:0] c_ZERO_REG = '0;

  prio_e                     prio_q, prio_d;
  logic                      we_q, we_d;
  logic [REG_ADDR_SIZE-1:0]  wreg_q, wreg_d;
  logic [REG_SIZE-1:0]       wdata_q, wdata_d;

  logic                      w_grant_alu;
  logic                      w_grant_mem;
  logic [REG_ADDR_SIZE-1:0]  w_win_reg;
  logic [REG_SIZE-1:0]       w_win_data;
  logic                      w_win_writable;

  // Arbitration: the output stage never stalls, so every cycle with a valid
  // request produces exactly one grant. Nothing is granted while in reset.
  always_comb begin
    w_grant_alu = 1'b0;
    w_grant_mem = 1'b0;
    prio_d      = prio_q;
    if (rst_n) begin
      if (alu_valid && mem_valid) begin
        if (prio_q == PRIO_ALU) begin
          w_grant_alu = 1'b1;
          prio_d      = PRIO_MEM;
        end else begin
          w_grant_mem = 1'b1;
          prio_d      = PRIO_ALU;
        end
      end else if (alu_valid) begin
        w_grant_alu = 1'b1;
        prio_d      = PRIO_MEM;
      end else if (mem_valid) begin
        w_grant_mem = 1'b1;
        prio_d      = PRIO_ALU;
      end
    end
  end

  assign alu_ready = w_grant_alu;
  assign mem_ready = w_grant_mem;

  // Winner selection; register 0 and indices beyond the register file are
  // accepted but never written.
  always_comb begin
    w_win_reg      = w_grant_mem ? mem_reg  : alu_reg;
    w_win_data     = w_grant_mem ? mem_data : alu_data;
    w_win_writable = (w_win_reg != c_ZERO_REG) && (32'(w_win_reg) < NUM_REGS);
  end

  // Next-state for the one-entry write stage; address/data hold when idle.
  always_comb begin
    we_d    = 1'b0;
    wreg_d  = wreg_q;
    wdata_d = wdata_q;
    if (w_grant_alu || w_grant_mem) begin
      we_d    = w_win_writable;
      wreg_d  = w_win_reg;
      wdata_d = w_win_data;
    end
  end

  // State registers; reset discards any staged write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_q  <= PRIO_ALU;
      we_q    <= 1'b0;
      wreg_q  <= '0;
      wdata_q <= '0;
    end else begin
      prio_q  <= prio_d;
      we_q    <= we_d;
      wreg_q  <= wreg_d;
      wdata_q <= wdata_d;
    end
  end

  assign WriteEnable = we_q;
  assign WriteReg    = wreg_q;
  assign WriteData   = wdata_q;

  // Bypass: the staged write is not yet in the regfile, so reads of the same
  // register take it from here. Data is always presented; hit qualifies it.
  always_comb begin
    fwd_a_hit  = we_q && (wreg_q == RegA) && (RegA != c_ZERO_REG);
    fwd_b_hit  = we_q && (wreg_q == RegB) && (RegB != c_ZERO_REG);
    fwd_a_data = wdata_q;
    fwd_b_data = wdata_q;
  end

endmodule
`default_nettype wire
